// File: rtl/note_sequencer.sv
// Song sequencer: walks a synchronous song ROM and holds each note code on the
// tone path for its duration in ms. Define SEQ_GAP_EN to add a silent gap after every entry.
module note_sequencer #(
  parameter int ADDR_W = 5,
  parameter int GAP_MS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ticks_per_milli,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [3:0]        tone_code,
  output logic              tone_en,
  output logic [7:0]        led,
  output logic              busy,
  output logic              done
);

`ifdef SEQ_GAP_EN
  localparam bit GAP_COMPILED = 1'b1;
`else
  localparam bit GAP_COMPILED = 1'b0;
`endif
  localparam bit GAP_ON = GAP_COMPILED && (GAP_MS > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
`ifdef SEQ_GAP_EN
    S_GAP,
`endif
    S_PLAY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]        tone_code_q, tone_code_d;
  logic              tone_en_q, tone_en_d;
  logic              done_q, done_d;
  logic [15:0]       mcnt_q, mcnt_d;
  logic [11:0]       remaining_q, remaining_d;
`ifdef SEQ_GAP_EN
  logic [15:0]       gap_cnt_q, gap_cnt_d;
`endif

  logic [15:0] t_eff;
  logic        ms_tick;
  logic        advance;
  logic        end_of_song;

  // A programmed rate of 0 behaves as one cycle per ms.
  assign t_eff   = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
  assign ms_tick = (mcnt_q >= t_eff - 16'd1);

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    tone_code_d = tone_code_q;
    tone_en_d   = tone_en_q;
    done_d      = 1'b0;
    mcnt_d      = 16'd0;
    remaining_d = remaining_q;
`ifdef SEQ_GAP_EN
    gap_cnt_d   = gap_cnt_q;
`endif
    advance     = 1'b0;
    end_of_song = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rom_data[11:0] == 12'd0) begin
          end_of_song = 1'b1;
        end else begin
          tone_code_d = rom_data[15:12];
          remaining_d = rom_data[11:0];
          tone_en_d   = (rom_data[15:12] != 4'd0);
          state_d     = S_PLAY;
        end
      end
      S_PLAY: begin
        mcnt_d = ms_tick ? 16'd0 : mcnt_q + 16'd1;
        if (ms_tick) begin
          remaining_d = remaining_q - 12'd1;
          if (remaining_q == 12'd1) begin
            tone_en_d   = 1'b0;
            tone_code_d = 4'd0;
            if (GAP_ON) begin
`ifdef SEQ_GAP_EN
              state_d   = S_GAP;
              gap_cnt_d = 16'd0;
              mcnt_d    = 16'd0;
`endif
            end else begin
              advance = 1'b1;
            end
          end
        end
      end
`ifdef SEQ_GAP_EN
      S_GAP: begin
        mcnt_d = ms_tick ? 16'd0 : mcnt_q + 16'd1;
        if (ms_tick) begin
          if (gap_cnt_q == 16'(GAP_MS - 1)) advance = 1'b1;
          else gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // The last ROM slot doubles as an implicit end-of-song marker.
    if (advance) begin
      if (rom_addr_q == '1) begin
        end_of_song = 1'b1;
      end else begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = S_FETCH;
      end
    end

    if (end_of_song) begin
      if (loop) begin
        rom_addr_d = '0;
        state_d    = S_FETCH;
      end else begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    if (stop) begin
      state_d     = S_IDLE;
      tone_en_d   = 1'b0;
      tone_code_d = 4'd0;
      done_d      = 1'b0;
      remaining_d = 12'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      tone_code_q <= 4'd0;
      tone_en_q   <= 1'b0;
      done_q      <= 1'b0;
      mcnt_q      <= 16'd0;
      remaining_q <= 12'd0;
`ifdef SEQ_GAP_EN
      gap_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      tone_code_q <= tone_code_d;
      tone_en_q   <= tone_en_d;
      done_q      <= done_d;
      mcnt_q      <= mcnt_d;
      remaining_q <= remaining_d;
`ifdef SEQ_GAP_EN
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  assign rom_addr  = rom_addr_q;
  assign tone_code = tone_code_q;
  assign tone_en   = tone_en_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign led       = tone_en_q ? (8'd1 << tone_code_q[2:0]) : 8'd0;

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Song sequencer that drives the music processor's tone path. On a start pulse it walks a synchronous song ROM and presents each note code to the tone generator for its programmed duration in milliseconds. Millisecond timing comes from the top-level `ticks_per_milli` value (100 or 10 ticks per ms). The sequencer also drives the LED segment pattern and handles looping, stopping and the end-of-song marker.

## Interface
Parameters:
- `ADDR_W`, default 5: song ROM address width (32 entries).
- `GAP_MS`, default 20: length of the silent inter-note gap in ms, used only when `SEQ_GAP_EN` is defined.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `ticks_per_milli` in 16: clock cycles per ms. A value of 0 is treated as 1.
- `start` in 1: pulse that begins playback from entry 0. Ignored while `busy`=1.
- `stop` in 1: abort playback.
- `loop` in 1: replay the song from entry 0 at its end.
- `rom_addr` out ADDR_W: registered ROM address.
- `rom_data` in 16: ROM word, valid one cycle after `rom_addr` changes.
  - `[15:12]` note code (0 = rest).
  - `[11:0]` duration in ms (0 = end-of-song marker).
- `tone_code` out 4: note code for the tone generator. Registered.
- `tone_en` out 1: tone generator enable.
- `led` out 8: one-hot `1<<tone_code[2:0]` while `tone_en`=1, otherwise 0.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on natural song end.

## Operation
- Millisecond counter `mcnt`:
  - Counts clock cycles and emits `ms_tick` when `mcnt >= T-1`, where T = max(`ticks_per_milli`, 1).
  - Returns to 0 after the tick.
  - Cleared on entry to PLAY or GAP.
  - T is sampled every cycle, so a change takes effect at the current comparison.
- IDLE: all outputs except `rom_addr` are 0. On `start`: `rom_addr`<=0, go to FETCH.
- FETCH: one wait cycle for the synchronous ROM, then go to LOAD.
- LOAD: capture `rom_data`.
  - Duration 0 with `loop`=1: `rom_addr`<=0, go to FETCH.
  - Duration 0 with `loop`=0: pulse `done`, go to IDLE.
  - Otherwise: `tone_code`<=code, `remaining`<=duration, `tone_en`<=(code!=0), go to PLAY.
- PLAY: decrement `remaining` on each `ms_tick`. On the tick where `remaining`==1:
  - `tone_en`<=0 and `tone_code`<=0.
  - Go to GAP if `SEQ_GAP_EN` is defined and GAP_MS>0.
  - Otherwise advance.
- GAP: count GAP_MS ms ticks with `tone_en`=0, then advance.
- Advance:
  - If `rom_addr` is 2^ADDR_W-1, treat it as an end-of-song marker, applying the same `loop`/`done` rule as LOAD.
  - Otherwise `rom_addr`<=`rom_addr`+1 and go to FETCH.
- `stop` in any state: the next state is IDLE and `tone_en`/`tone_code`/`led`/`busy` clear next cycle. No `done` pulse.
  - `stop` and `start` in the same cycle: `stop` wins and the sequencer stays in IDLE.
- `loop` is sampled only at the end-of-song decision.
- A rest entry (code 0, nonzero duration) holds silence for its duration. `led`=0 during a rest.

## Timing
- Reset values:
  - State IDLE.
  - `rom_addr`=0, `tone_code`=0, `tone_en`=0, `led`=0, `busy`=0, `done`=0.
  - `mcnt`=0, `remaining`=0.
- Reset mid-playback: outputs return to reset values on the cycle after `rst` is sampled high.
- `start` sampled in cycle 0:
  - `busy`=1 and FETCH in cycle 1.
  - LOAD in cycle 2.
  - `tone_en`/`tone_code`/`led` valid from cycle 3.
- A note of D ms keeps `tone_en` high for exactly D·T cycles.
- Without a gap, `tone_en` is low for exactly 2 cycles (FETCH, LOAD) between consecutive notes.
- With a gap, `tone_en` is low for GAP_MS·T + 2 cycles between consecutive notes.
- `done` is asserted in the cycle IDLE is entered. `busy` is 0 in the same cycle.

## Configuration
- `SEQ_GAP_EN` defined: the GAP state is compiled in, and a GAP_MS silent gap follows every note and rest.
- `SEQ_GAP_EN` undefined: the GAP state and its counter are absent, and PLAY advances directly to FETCH.

## Test plan
- ROM = {0x3005, 0x0002, 0x0000}, T=10, gap off, `start` pulse at cycle 0:
  - `tone_en`=1 and `led`=0x08 for cycles 3..52.
  - Rest ends at cycle 74; `done` pulse at cycle 77, with `busy`=0 in the same cycle.
- Same ROM, T=0: treated as T=1, so the note lasts 5 cycles.
- Same ROM with `loop`=1: after the marker, `rom_addr` returns to 0 and code 3 replays. Then `stop` mid-note: `tone_en`=0 and `busy`=0 the next cycle, with no `done` pulse.
- ROM with no zero-duration marker (32 entries of 0x1001), T=1, `loop`=0: after entry 31, `done` pulses and `rom_addr` does not wrap into a replay.
- `SEQ_GAP_EN` defined, GAP_MS=20, ROM {0x2001, 0x4001, 0x0000}, T=10: `tone_en` is low for 202 cycles between the two notes.
- Disturbances:
  - `start` asserted during PLAY is ignored (`rom_addr` unchanged).
  - `start` and `stop` in the same cycle from IDLE: stays IDLE.
  - `rst` in PLAY: all outputs 0 next cycle.
